// File: rtl/snn_grid_1x1_wrapper.sv
// snn_grid_1x1_wrapper
// Single-core 1x1 spiking-neural-network block: 256 axons x 256 neurons,
// integrate-and-fire, one neuron evaluated per 257-clock slot after a tick.
//
// Ports
//   clk, reset                 : rising-edge clock, async active-high reset
//   tick                       : one-cycle pulse starting a timestep
//   packet_winc/wdata/wfull    : spike packet injection into the delay scheduler
//   param_winc/wdata/wfull     : sequential neuron parameter load (auto-increment)
//   neuron_inst_winc/wdata/wfull : sequential axon type load (auto-increment)
//   packet_out, packet_out_valid : outgoing spike (destination axon) and strobe
//   token_controller_error     : sticky, tick seen while busy
//   scheduler_error            : sticky, write attempted while its wfull was high
//
// Build option: SNN_LOCAL_ROUTE_EN routes dx=dy=0 spikes back into the local
// scheduler instead of packet_out.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for tick, host writes accepted
// LATCH     | copy scheduler slot to active axons, clear slot, advance ptr
// INTEGRATE | one axon per cycle accumulated into current neuron potential
// FIRE      | leak, threshold, spike, write potential back

module snn_grid_1x1_wrapper (
    input  logic         clk,
    input  logic         reset,
    input  logic         tick,
    input  logic         packet_winc,
    input  logic [29:0]  packet_wdata,
    output logic         packet_wfull,
    input  logic         param_winc,
    input  logic [367:0] param_wdata,
    output logic         param_wfull,
    input  logic         neuron_inst_winc,
    input  logic [1:0]   neuron_inst_wdata,
    output logic         neuron_inst_wfull,
    output logic [7:0]   packet_out,
    output logic         packet_out_valid,
    output logic         token_controller_error,
    output logic         scheduler_error
);
    typedef enum logic [1:0] {IDLE, LATCH, INTEGRATE, FIRE} state_t;
    state_t state, state_nxt;

    logic [367:0] param_mem [256];
    logic [1:0]   inst_mem  [256];
    logic [8:0]   pot_mem   [256];
    logic [255:0] sched     [16];
    logic [255:0] active;
    logic [7:0]   param_ptr, inst_ptr, axon_idx, neuron_idx;
    logic [3:0]   tick_ptr;
    logic signed [8:0] v_acc;

    logic [367:0] cur;
    logic [255:0] syn_vec;
    logic signed [8:0] w_sel, leak, pos_th, neg_th, rst_pot;
    logic signed [8:0] v_leak, v_new, neg_lim;
    logic spike, route_out, pkt_wr, param_wr, inst_wr;
    logic [3:0] pkt_slot;
    logic unused_bits;

    function automatic logic signed [8:0] sat9(input logic [9:0] s);
        if (s[9] != s[8]) return s[9] ? 9'h100 : 9'h0FF;
        return s[8:0];
    endfunction

    function automatic logic signed [8:0] sat_add(input logic [8:0] a, input logic [8:0] b);
        return sat9({a[8], a} + {b[8], b});
    endfunction

    function automatic logic signed [8:0] sat_sub(input logic [8:0] a, input logic [8:0] b);
        return sat9({a[8], a} - {b[8], b});
    endfunction

    assign cur      = param_mem[neuron_idx];
    assign syn_vec  = cur[367:112];
    assign rst_pot  = cur[102:94];
    assign leak     = cur[57:49];
    assign pos_th   = cur[48:40];
    assign neg_th   = cur[39:31];
    assign pkt_wr   = packet_winc && !packet_wfull;
    assign param_wr = param_winc && !param_wfull;
    assign inst_wr  = neuron_inst_winc && !neuron_inst_wfull;
    assign pkt_slot = tick_ptr + packet_wdata[3:0];

    always_comb begin
        case (inst_mem[axon_idx])
            2'd0:    w_sel = cur[93:85];
            2'd1:    w_sel = cur[84:76];
            2'd2:    w_sel = cur[75:67];
            default: w_sel = cur[66:58];
        endcase
    end

    always_comb begin
        v_leak  = sat_add(v_acc, leak);
        neg_lim = sat_sub(9'd0, neg_th);
        spike   = (v_leak >= pos_th);
        if (spike)
            v_new = cur[30] ? rst_pot : sat_sub(v_leak, pos_th);
        else if (v_leak < neg_lim)
            v_new = cur[30] ? sat_sub(9'd0, rst_pot) : neg_lim;
        else
            v_new = v_leak;
    end

`ifdef SNN_LOCAL_ROUTE_EN
    logic       local_wr;
    logic [3:0] local_slot;
    assign route_out   = (cur[29:21] != 9'd0) || (cur[20:12] != 9'd0);
    assign local_wr    = (state == FIRE) && spike && !route_out;
    // tick_ptr has already advanced past the slot latched for this timestep
    assign local_slot  = tick_ptr + cur[3:0];
    assign unused_bits = ^{packet_wdata[29:12], cur[111:103]};
`else
    assign route_out   = 1'b1;
    assign unused_bits = ^{packet_wdata[29:12], cur[111:103], cur[29:12], cur[3:0]};
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt         = state;
        packet_wfull      = 1'b0;
        param_wfull       = 1'b0;
        neuron_inst_wfull = 1'b0;
        packet_out_valid  = 1'b0;
        packet_out        = 8'd0;
        case (state)
            IDLE: begin
                if (tick) state_nxt = LATCH;
            end
            LATCH: begin
                packet_wfull      = 1'b1;
                param_wfull       = 1'b1;
                neuron_inst_wfull = 1'b1;
                state_nxt         = INTEGRATE;
            end
            INTEGRATE: begin
                param_wfull       = 1'b1;
                neuron_inst_wfull = 1'b1;
                if (axon_idx == 8'd255) state_nxt = FIRE;
            end
            FIRE: begin
                param_wfull       = 1'b1;
                neuron_inst_wfull = 1'b1;
                if (spike && route_out) begin
                    packet_out_valid = 1'b1;
                    packet_out       = cur[11:4];
                end
                state_nxt = (neuron_idx == 8'd255) ? IDLE : INTEGRATE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (param_wr) param_mem[param_ptr] <= param_wdata;
        if (inst_wr)  inst_mem[inst_ptr]   <= neuron_inst_wdata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) pot_mem[i] <= '0;
        end else if (param_wr) begin
            pot_mem[param_ptr] <= param_wdata[111:103];
        end else if (state == FIRE) begin
            pot_mem[neuron_idx] <= v_new;
        end
    end

    // A write in the tick cycle lands before LATCH copies the slot out.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) sched[i] <= '0;
        end else begin
            if (state == LATCH) sched[tick_ptr] <= '0;
            if (pkt_wr) sched[pkt_slot][packet_wdata[11:4]] <= 1'b1;
`ifdef SNN_LOCAL_ROUTE_EN
            if (local_wr) sched[local_slot][cur[11:4]] <= 1'b1;
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active                 <= '0;
            tick_ptr               <= '0;
            axon_idx               <= '0;
            neuron_idx             <= '0;
            v_acc                  <= '0;
            param_ptr              <= '0;
            inst_ptr               <= '0;
            token_controller_error <= 1'b0;
            scheduler_error        <= 1'b0;
        end else begin
            if (param_wr) param_ptr <= param_ptr + 8'd1;
            if (inst_wr)  inst_ptr  <= inst_ptr + 8'd1;
            if (tick && state != IDLE) token_controller_error <= 1'b1;
            if ((packet_winc && packet_wfull) || (param_winc && param_wfull) ||
                (neuron_inst_winc && neuron_inst_wfull))
                scheduler_error <= 1'b1;
            case (state)
                LATCH: begin
                    active     <= sched[tick_ptr];
                    tick_ptr   <= tick_ptr + 4'd1;
                    axon_idx   <= '0;
                    neuron_idx <= '0;
                    v_acc      <= pot_mem[0];
                end
                INTEGRATE: begin
                    // synapse bit for axon j sits at syn_vec[255-j]
                    if (active[axon_idx] && syn_vec[~axon_idx])
                        v_acc <= sat_add(v_acc, w_sel);
                    axon_idx <= axon_idx + 8'd1;
                end
                FIRE: begin
                    neuron_idx <= neuron_idx + 8'd1;
                    v_acc      <= pot_mem[neuron_idx + 8'd1];
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_snn_grid_1x1_wrapper.sv
module tb_snn_grid_1x1_wrapper;
    logic         clk = 1'b0;
    logic         reset, tick, packet_winc, param_winc, neuron_inst_winc;
    logic [29:0]  packet_wdata;
    logic [367:0] param_wdata;
    logic [1:0]   neuron_inst_wdata;
    logic         packet_wfull, param_wfull, neuron_inst_wfull;
    logic [7:0]   packet_out;
    logic         packet_out_valid, token_controller_error, scheduler_error;

    always #5 clk = ~clk;

    snn_grid_1x1_wrapper dut (
        .clk(clk), .reset(reset), .tick(tick),
        .packet_winc(packet_winc), .packet_wdata(packet_wdata), .packet_wfull(packet_wfull),
        .param_winc(param_winc), .param_wdata(param_wdata), .param_wfull(param_wfull),
        .neuron_inst_winc(neuron_inst_winc), .neuron_inst_wdata(neuron_inst_wdata),
        .neuron_inst_wfull(neuron_inst_wfull),
        .packet_out(packet_out), .packet_out_valid(packet_out_valid),
        .token_controller_error(token_controller_error), .scheduler_error(scheduler_error)
    );

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [3:0] syn;
        int init, w0, w1, w2, w3, leak, pth, dx, dy;
        bit exp_spike;
    } vec_t;
    vec_t tbl[12];

    logic [255:0] c_syn [256];
    int c_init[256], c_w[256][4], c_leak[256], c_pth[256], c_nth[256];
    int c_dx[256], c_dy[256], c_dest[256];
    int inst_ref[256];
    logic [255:0] act_ax;
    bit exp_spike[256];
    logic [29:0] hook_pkt;
    int busy;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mv(input logic [3:0] syn, input int init, input int w0, input int w1,
                                input int w2, input int w3, input int leak, input int pth,
                                input int dx, input int dy, input bit exp_spike);
        vec_t v;
        v.syn = syn; v.init = init; v.w0 = w0; v.w1 = w1; v.w2 = w2; v.w3 = w3;
        v.leak = leak; v.pth = pth; v.dx = dx; v.dy = dy; v.exp_spike = exp_spike;
        return v;
    endfunction

    function automatic int clamp(input int v);
        if (v > 255) return 255;
        if (v < -256) return -256;
        return v;
    endfunction

    // Reference: first timestep of a neuron from its parameters and the active axon set
    function automatic bit model_spike(input int n);
        int v = c_init[n];
        for (int j = 0; j < 256; j++)
            if (act_ax[j] && c_syn[n][j]) v = clamp(v + c_w[n][inst_ref[j]]);
        v = clamp(v + c_leak[n]);
        return v >= c_pth[n];
    endfunction

    function automatic logic [367:0] pack(input int n);
        logic [367:0] p = '0;
        for (int j = 0; j < 256; j++) p[367 - j] = c_syn[n][j];
        p[111:103] = 9'(c_init[n]);
        p[93:85]   = 9'(c_w[n][0]);
        p[84:76]   = 9'(c_w[n][1]);
        p[75:67]   = 9'(c_w[n][2]);
        p[66:58]   = 9'(c_w[n][3]);
        p[57:49]   = 9'(c_leak[n]);
        p[48:40]   = 9'(c_pth[n]);
        p[39:31]   = 9'(c_nth[n]);
        p[29:21]   = 9'(c_dx[n]);
        p[20:12]   = 9'(c_dy[n]);
        p[11:4]    = 8'(c_dest[n]);
        return p;
    endfunction

    task automatic set_defaults();
        for (int i = 0; i < 256; i++) begin
            c_syn[i] = '0; c_init[i] = 0; c_leak[i] = 0; c_pth[i] = 255; c_nth[i] = 100;
            for (int k = 0; k < 4; k++) c_w[i][k] = 0;
            c_dx[i] = 1; c_dy[i] = 0; c_dest[i] = i; inst_ref[i] = 0; exp_spike[i] = 1'b0;
        end
        act_ax = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; tick = 1'b0; packet_winc = 1'b0; param_winc = 1'b0; neuron_inst_winc = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic load_all();
        for (int i = 0; i < 256; i++) begin
            @(negedge clk); param_winc = 1'b1; param_wdata = pack(i);
        end
        @(negedge clk); param_winc = 1'b0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk); neuron_inst_winc = 1'b1; neuron_inst_wdata = 2'(inst_ref[i]);
        end
        @(negedge clk); neuron_inst_winc = 1'b0;
    endtask

    task automatic write_pkt(input int axon, input int delay);
        @(negedge clk);
        packet_winc = 1'b1; packet_wdata = {18'd0, 8'(axon), 4'(delay)};
        @(negedge clk);
        packet_winc = 1'b0;
    endtask

    // Cycle c counts rising edges since tick was driven; LATCH is c=1,
    // FIRE of neuron n is c = 1 + n*257 + 257.
    task automatic run_step(input int n_cycles, input int n_check, input int hook_cnt,
                            input bit tick_pkt_en, input logic [29:0] tick_pkt, output int busy_cnt);
        int stray = 0;
        int n;
        busy_cnt = 0;
        @(negedge clk);
        tick = 1'b1; packet_winc = tick_pkt_en; packet_wdata = tick_pkt;
        for (int c = 1; c <= n_cycles; c++) begin
            @(negedge clk);
            tick = 1'b0; packet_winc = 1'b0; param_winc = 1'b0;
            if (param_wfull) busy_cnt++;
            if (c == 1) check("latch_packet_wfull", packet_wfull, 1);
            if (c == 2) begin
                check("integ_packet_wfull", packet_wfull, 0);
                check("integ_param_wfull", param_wfull, 1);
                check("integ_inst_wfull", neuron_inst_wfull, 1);
            end
            if (c >= 258 && (c - 258) % 257 == 0) begin
                n = (c - 258) / 257;
                if (n < n_check) begin
                    check($sformatf("fire_n%0d_valid", n), packet_out_valid, exp_spike[n]);
                    if (exp_spike[n])
                        check($sformatf("fire_n%0d_dest", n), packet_out, c_dest[n]);
                end
            end else if (packet_out_valid) begin
                stray++;
            end
            if (c == hook_cnt) begin
                tick = 1'b1; param_winc = 1'b1; packet_winc = 1'b1; packet_wdata = hook_pkt;
            end
        end
        check("stray_pulses", stray, 0);
    endtask

    initial begin
        bit local_rt;
`ifdef SNN_LOCAL_ROUTE_EN
        local_rt = 1'b1;
`else
        local_rt = 1'b0;
`endif
        //            syn     init  w0    w1    w2   w3 leak  pth  dx dy spike
        tbl[0]  = mv(4'b0001,  0,   10,    0,   0,  0,    0,   10, 1, 0, 1);
        tbl[1]  = mv(4'b0001,  0,    9,    0,   0,  0,    0,   10, 1, 0, 0);
        tbl[2]  = mv(4'b0011,  0,  255,  255,   0,  0,    0,  255, 1, 0, 1);
        tbl[3]  = mv(4'b0100,  0,    0,    0, -20,  0,    0,    1, 1, 0, 0);
        tbl[4]  = mv(4'b1000,  0,    0,    0,   0,  5,    5,   10, 0, 1, 1);
        tbl[5]  = mv(4'b1111,  0,    1,    2,   3,  4,   -1,    9, 1, 0, 1);
        tbl[6]  = mv(4'b0000,  0,    0,    0,   0,  0,    0,    0, 1, 0, 1);
        tbl[7]  = mv(4'b0001,  0,  100,    0,   0,  0, -100,    1, 1, 0, 0);
        tbl[8]  = mv(4'b0000, 50,    0,    0,   0,  0,    0,   50, 1, 0, 1);
        tbl[9]  = mv(4'b0011,  0, -200, -200,   0,  0,    0, -255, 1, 0, 0);
        tbl[10] = mv(4'b0001,  0, -256,    0,   0,  0, -256, -256, 1, 0, 1);
        tbl[11] = mv(4'b0001,  0,    1,    0,   0,  0,    0,    1, 0, 0, !local_rt);

        packet_wdata = '0; param_wdata = '0; neuron_inst_wdata = '0; hook_pkt = '0;
        do_reset();
        @(negedge clk);
        check("rst_packet_out", packet_out, 0);
        check("rst_valid", packet_out_valid, 0);
        check("rst_packet_wfull", packet_wfull, 0);
        check("rst_param_wfull", param_wfull, 0);
        check("rst_inst_wfull", neuron_inst_wfull, 0);
        check("rst_token_err", token_controller_error, 0);
        check("rst_sched_err", scheduler_error, 0);

        // Table neurons 0..11 plus randomized neurons 12..23, one partial timestep
        set_defaults();
        for (int j = 0; j < 4; j++) inst_ref[j] = j;
        for (int j = 4; j < 32; j++) inst_ref[j] = int'($urandom_range(3));
        act_ax[3:0] = 4'hF;
        for (int j = 4; j < 32; j++) act_ax[j] = 1'($urandom_range(1));
        for (int i = 0; i < 12; i++) begin
            c_syn[i] = {252'd0, tbl[i].syn};
            c_init[i] = tbl[i].init;
            c_w[i][0] = tbl[i].w0; c_w[i][1] = tbl[i].w1; c_w[i][2] = tbl[i].w2; c_w[i][3] = tbl[i].w3;
            c_leak[i] = tbl[i].leak; c_pth[i] = tbl[i].pth;
            c_dx[i] = tbl[i].dx; c_dy[i] = tbl[i].dy; c_dest[i] = 100 + i;
            exp_spike[i] = tbl[i].exp_spike;
        end
        for (int i = 12; i < 24; i++) begin
            c_syn[i] = {224'd0, 32'($urandom())};
            c_init[i] = int'($urandom_range(511)) - 256;
            for (int k = 0; k < 4; k++) c_w[i][k] = int'($urandom_range(511)) - 256;
            c_leak[i] = int'($urandom_range(40)) - 20;
            c_pth[i] = int'($urandom_range(200)) - 100;
            c_nth[i] = int'($urandom_range(255));
            c_dx[i] = int'($urandom_range(3, 1));
            c_dest[i] = int'($urandom_range(255));
            exp_spike[i] = model_spike(i);
        end
        load_all();
        for (int j = 0; j < 32; j++) if (act_ax[j]) write_pkt(j, 0);
        run_step(258 + 23 * 257, 24, -1, 1'b0, 30'd0, busy);
        check("a_token_err", token_controller_error, 0);
        check("a_sched_err", scheduler_error, 0);
        do_reset();
        @(negedge clk);
        check("abort_idle", param_wfull, 0);
        check("abort_valid", packet_out_valid, 0);

        // Multi-tick scheduling scenario
        set_defaults();
        c_syn[5][3]  = 1'b1; c_w[5][0] = 10; c_pth[5] = 10; c_dest[5] = 7;
        c_syn[6][9]  = 1'b1; c_w[6][0] = 10; c_pth[6] = 10; c_dest[6] = 60;
        c_syn[7][12] = 1'b1; c_w[7][0] = 10; c_pth[7] = 10; c_dest[7] = 70;
        c_syn[8][20] = 1'b1; c_w[8][0] = 10; c_pth[8] = 10; c_dest[8] = 80;
        c_syn[9][13] = 1'b1; c_w[9][0] = 10; c_pth[9] = 10; c_dest[9] = 90;
        load_all();
        write_pkt(3, 0);
        write_pkt(9, 1);
        write_pkt(20, 2);
        exp_spike[5] = 1'b1;
        hook_pkt = {18'd0, 8'd12, 4'd0};
        run_step(65794, 256, 1000, 1'b0, 30'd0, busy);
        check("timestep_busy_cycles", busy, 65793);
        check("b_token_err", token_controller_error, 1);
        check("b_sched_err", scheduler_error, 1);

        for (int i = 0; i < 256; i++) exp_spike[i] = 1'b0;
        exp_spike[6] = 1'b1;
        exp_spike[7] = 1'b1;
        exp_spike[9] = 1'b1;
        run_step(258 + 9 * 257, 10, -1, 1'b1, {18'd0, 8'd13, 4'd0}, busy);
        check("c_token_err_sticky", token_controller_error, 1);
        check("c_sched_err_sticky", scheduler_error, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
